fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, framebuffer word address width.
REQ-002 SHALL have parameter DATA_W, default 8, framebuffer word width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, max cycles a writer waits during the active row before a forced write slot.
REQ-004 SHALL have port sys_clk  in  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port row_enable  in  1  1 during active video row, 0 during sync/blanking.
REQ-007 SHALL have ports vid_req in 1, vid_addr in ADDR_W; video scan-out read request, valid/ready style.
REQ-008 SHALL have port vid_gnt  out  1  read accepted this cycle when vid_req=1.
REQ-009 SHALL have ports vid_rvalid out 1, vid_rdata out DATA_W; read data return.
REQ-010 SHALL have ports wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W; drawing-side write request.
REQ-011 SHALL have port wr_ack  out  1  write accepted this cycle when wr_req=1.
REQ-012 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W; single-port synchronous RAM, read latency 1.
REQ-013 SHALL have port vid_miss  out  1  registered one-cycle pulse: video request refused while row_enable=1.

Function
REQ-014 SHALL perform at most one memory access per cycle; a transfer occurs when req and its grant are both 1 in the same cycle.
REQ-015 SHALL compute vid_gnt, wr_ack and mem_* combinationally from requests, mode and starve counter.
REQ-016 SHALL keep mode FSM states PRI_WR, PRI_VID, FORCE_WR.
REQ-017 PRI_WR: wr_ack=wr_req; vid_gnt=vid_req and not wr_req; next PRI_VID if row_enable else PRI_WR.
REQ-018 PRI_VID: vid_gnt=vid_req; wr_ack=wr_req and not vid_req; next PRI_WR if not row_enable, else FORCE_WR if wr_req, not acked, starve=STARVE_MAX-1, else PRI_VID.
REQ-019 FORCE_WR: lasts exactly one cycle; grants as PRI_WR; next PRI_VID if row_enable else PRI_WR.
REQ-020 Mode SHALL follow row_enable with one cycle lag; no combinational path from row_enable to grants.
REQ-021 Starve counter (width clog2(STARVE_MAX)+1): +1 per cycle wr_req=1 and wr_ack=0 in PRI_VID; cleared on wr_ack, on wr_req=0, or on leaving PRI_VID; saturates at STARVE_MAX.
REQ-022 Write transfer: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
REQ-023 Read transfer: mem_en=1, mem_we=0, mem_addr=vid_addr; vid_rvalid=1 next cycle, vid_rdata=mem_rdata in that cycle.
REQ-024 No transfer: mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care (driven 0).
REQ-025 vid_miss SHALL pulse the cycle after vid_req=1, vid_gnt=0, row_enable=1.
REQ-026 Back-to-back grants to the same requester in consecutive cycles SHALL be allowed.

Reset
REQ-027 On sys_rst: mode=PRI_WR, starve=0, vid_rvalid=0, vid_miss=0, immediately and asynchronously.
REQ-028 While sys_rst=1, vid_gnt, wr_ack, mem_en, mem_we SHALL be 0.
REQ-029 A read granted in the cycle reset asserts SHALL NOT produce vid_rvalid.

Structure
REQ-030 fb_pkg SHALL hold ADDR_W/DATA_W/STARVE_MAX defaults and the mode state enum.
REQ-031 Single module; no sub-module.

Verification (STARVE_MAX=8)
REQ-032 row_enable=0, vid_req=wr_req=1 at one cycle -> wr_ack=1, vid_gnt=0, mem_we=1; next cycle wr_req=0 -> vid_gnt=1, vid_rvalid following cycle.
REQ-033 row_enable=1 (settled), vid_req and wr_req held 1 -> vid_gnt 7 cycles, FORCE_WR cycle 8: wr_ack=1, vid_gnt=0, vid_miss pulses once cycle 9.
REQ-034 RAM model holding 0xA5 at addr 0x0123, vid_addr=0x0123 granted -> vid_rvalid=1, vid_rdata=0xA5 exactly 1 cycle later.
REQ-035 row_enable 0->1 with both requests pending -> writer still wins first cycle (lag), video wins from second cycle.
REQ-036 sys_rst asserted mid-read and mid-starve (count 5) -> vid_rvalid stays 0, after release mode=PRI_WR, counter restarts from 0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer arbiter defaults and mode state encoding.
package fb_pkg;
    localparam int ADDR_W_DEF     = 13;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 8;
    typedef enum logic [1:0] {PRI_WR = 2'd0, PRI_VID = 2'd1, FORCE_WR = 2'd2} mode_e;
endpackage

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter between video scan-out reads and drawing writes.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              row_enable,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vid_miss
);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    mode_e          mode_q, mode_d;
    logic [SW-1:0]  starve_q, starve_d, starve_inc;
    logic           rvalid_q, miss_q, wr_pri, starved;
    always_comb begin
        wr_pri     = mode_q != PRI_VID;
        wr_ack     = !sys_rst && wr_req && (wr_pri || !vid_req);
        vid_gnt    = !sys_rst && vid_req && !(wr_pri && wr_req);
        mem_en     = wr_ack || vid_gnt;
        mem_we     = wr_ack;
        mem_addr   = wr_ack ? wr_addr : vid_gnt ? vid_addr : '0;
        mem_wdata  = wr_ack ? wr_data : '0;
        starved    = mode_q == PRI_VID && wr_req && !wr_ack;
        starve_inc = starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1;
        // the forced slot lands on the cycle the writer would otherwise wait for the STARVE_MAX-th time
        mode_d     = !row_enable ? PRI_WR :
                     mode_q != PRI_VID ? PRI_VID :
                     (starved && starve_inc == SW'(STARVE_MAX - 1)) ? FORCE_WR : PRI_VID;
        starve_d   = (starved && mode_d == PRI_VID) ? starve_inc : '0;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q   <= PRI_WR;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
            rvalid_q <= vid_gnt;
            miss_q   <= vid_req && !vid_gnt && row_enable;
        end
    end
    assign vid_rvalid = rvalid_q;
    assign vid_miss   = miss_q;
    assign vid_rdata  = mem_rdata;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter with a behavioural single-port RAM.
module tb_fb_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    logic          sys_clk = 1'b0, sys_rst = 1'b1, row_enable = 1'b0;
    logic          vid_req = 1'b0, wr_req = 1'b0;
    logic [AW-1:0] vid_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0, mem_rdata = '0;
    logic          vid_gnt, vid_rvalid, wr_ack, mem_en, mem_we, vid_miss;
    logic [DW-1:0] vid_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] sb [$];
    int            n_chk = 0, n_err = 0;
    logic          miss_exp = 1'b0;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .row_enable(row_enable),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vid_miss(vid_miss)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    always @(negedge sys_clk) begin
        if (sys_rst) sb.delete();
        else begin
            if (vid_rvalid) begin
                check("rv_pending", sb.size() != 0, 1);
                if (sb.size() != 0) check("rdata", vid_rdata, sb.pop_front());
            end
            if (vid_req && vid_gnt) sb.push_back(ram[vid_addr]);
        end
    end

    task automatic step(input string tag, input logic ev, input logic ew);
        #3;
        check({tag, "_vgnt"}, vid_gnt, ev);
        check({tag, "_wack"}, wr_ack, ew);
        check({tag, "_memen"}, mem_en, ev | ew);
        check({tag, "_memwe"}, mem_we, ew);
        check({tag, "_miss"}, vid_miss, miss_exp);
        miss_exp = vid_req && !ev && row_enable;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic burst(input string tag);
        step({tag, "_lag"}, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            vid_addr = AW'(i * 3 + 1);
            step({tag, "_vid"}, 1'b1, 1'b0);
        end
        step({tag, "_force"}, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 7 + 3);
        repeat (2) @(posedge sys_clk);
        #1;
        vid_req = 1'b1;
        wr_req  = 1'b1;
        #3;
        check("rst_vgnt", vid_gnt, 0);
        check("rst_wack", wr_ack, 0);
        check("rst_memen", mem_en, 0);
        check("rst_memwe", mem_we, 0);
        check("rst_rvalid", vid_rvalid, 0);
        check("rst_miss", vid_miss, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        wr_addr = 13'h0123;
        wr_data = 8'hA5;
        #3;
        check("a_wack", wr_ack, 1);
        check("a_vgnt", vid_gnt, 0);
        check("a_memwe", mem_we, 1);
        check("a_maddr", mem_addr, 13'h0123);
        check("a_mwdata", mem_wdata, 8'hA5);
        @(posedge sys_clk);
        #1;
        wr_req   = 1'b0;
        vid_addr = 13'h0123;
        #3;
        check("a_rd_vgnt", vid_gnt, 1);
        check("a_rd_memen", mem_en, 1);
        check("a_rd_memwe", mem_we, 0);
        check("a_rd_maddr", mem_addr, 13'h0123);
        @(posedge sys_clk);
        #1;
        vid_req = 1'b0;
        #3;
        check("a_rvalid", vid_rvalid, 1);
        check("a_rdata", vid_rdata, 8'hA5);
        check("a_idle_memen", mem_en, 0);
        @(posedge sys_clk);
        #1;
        check("a_rvalid_end", vid_rvalid, 0);
        row_enable = 1'b1;
        vid_req    = 1'b1;
        wr_req     = 1'b1;
        wr_addr    = 13'h1000;
        burst("b");
        row_enable = 1'b0;
        step("fall_lag", 1'b1, 1'b0);
        step("fall_wr", 1'b0, 1'b1);
        row_enable = 1'b1;
        burst("c");
        for (int i = 0; i < 5; i++) step("c_starve", 1'b1, 1'b0);
        vid_addr = 13'h0050;
        #3;
        check("c_mid_vgnt", vid_gnt, 1);
        #3;
        sys_rst = 1'b1;
        #1;
        check("c_rst_vgnt", vid_gnt, 0);
        check("c_rst_wack", wr_ack, 0);
        check("c_rst_memen", mem_en, 0);
        check("c_rst_memwe", mem_we, 0);
        @(posedge sys_clk);
        #1;
        check("c_rst_rvalid", vid_rvalid, 0);
        check("c_rst_miss", vid_miss, 0);
        @(posedge sys_clk);
        #1;
        check("c_rst_rvalid2", vid_rvalid, 0);
        sys_rst  = 1'b0;
        miss_exp = 1'b0;
        burst("r");
        vid_req = 1'b0;
        wr_req  = 1'b0;
        step("idle", 1'b0, 1'b0);
        step("idle2", 1'b0, 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
